// File: rtl/nibble_sequencer.sv
// Turns switches and push-buttons into a registered 4-bit value: synchronized and
// debounced inputs, manual load/step or timed auto-increment, with update/wrap strobes.
module nibble_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned TICK_DIV        = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw,
    input  logic       btn_load,
    input  logic       btn_step,
    input  logic       mode_auto,
    output logic [3:0] a,
    output logic       a_valid,
    output logic       wrap
);

    localparam int unsigned CntW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TickW = $clog2(TICK_DIV);
    localparam logic [CntW-1:0]  CntLast  = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);

    typedef enum logic {StManual, StAuto} state_e;

    // Index 0 is the load button, index 1 the step button.
    logic [3:0]           sw_s1, sw_s2;
    logic [1:0]           btn_s1, btn_s2;
    logic                 mode_s1, mode_s2;
    logic [1:0]           db_q, db_d, db_prev_q, ev_q;
    logic [1:0][CntW-1:0] cnt_q, cnt_d;

    state_e           state_q, state_d;
    logic [TickW-1:0] tick_q, tick_d;
    logic [3:0]       a_q, a_d;
    logic             a_valid_q, a_valid_d;
    logic             wrap_q, wrap_d;
    logic             ev_load, ev_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_s1   <= '0;
            sw_s2   <= '0;
            btn_s1  <= '0;
            btn_s2  <= '0;
            mode_s1 <= 1'b0;
            mode_s2 <= 1'b0;
        end else begin
            sw_s1   <= sw;
            sw_s2   <= sw_s1;
            btn_s1  <= {btn_step, btn_load};
            btn_s2  <= btn_s1;
            mode_s1 <= mode_auto;
            mode_s2 <= mode_s1;
        end
    end

    // The level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (btn_s2[i] != db_q[i]) begin
                if (cnt_q[i] == CntLast) begin
                    db_d[i] = ~db_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q      <= '0;
            cnt_q     <= '0;
            db_prev_q <= '0;
            ev_q      <= '0;
        end else begin
            db_q      <= db_d;
            cnt_q     <= cnt_d;
            db_prev_q <= db_q;
            ev_q      <= db_q & ~db_prev_q;
        end
    end

    assign ev_load = ev_q[0];
    assign ev_step = ev_q[1];

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        a_d       = a_q;
        a_valid_d = 1'b0;
        wrap_d    = 1'b0;
        case (state_q)
            StManual: begin
                if (ev_load) begin
                    a_d       = sw_s2;
                    a_valid_d = 1'b1;
                end else if (ev_step) begin
                    a_d       = a_q + 4'd1;
                    a_valid_d = 1'b1;
                    wrap_d    = (a_q == 4'hF);
                end
                if (mode_s2) begin
                    state_d = StAuto;
                    tick_d  = '0;
                end
            end
            StAuto: begin
                if (ev_load) begin
                    a_d       = sw_s2;
                    a_valid_d = 1'b1;
                    tick_d    = '0;
                end else if (mode_s2) begin
                    if (tick_q == TickLast) begin
                        tick_d    = '0;
                        a_d       = a_q + 4'd1;
                        a_valid_d = 1'b1;
                        wrap_d    = (a_q == 4'hF);
                    end else begin
                        tick_d = tick_q + TickW'(1);
                    end
                end
                // Leaving AUTO: no tick is taken on the way out.
                if (!mode_s2) begin
                    state_d = StManual;
                    tick_d  = '0;
                end
            end
            default: begin
                state_d = StManual;
                tick_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StManual;
            tick_q    <= '0;
            a_q       <= '0;
            a_valid_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            a_q       <= a_d;
            a_valid_q <= a_valid_d;
            wrap_q    <= wrap_d;
        end
    end

    assign a       = a_q;
    assign a_valid = a_valid_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_nibble_sequencer.sv
// Randomized bench for nibble_sequencer: button windows are recorded cycle by cycle and
// compared with an arithmetic model of latency, load/step values and auto tick spacing.
module tb_nibble_sequencer;

    localparam int unsigned DEB  = 16;
    localparam int unsigned TDIV = 4;
    localparam int          LAT  = DEB + 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sw;
    logic       btn_load, btn_step, mode_auto;
    logic [3:0] a;
    logic       a_valid, wrap;

    int n_pass = 0;
    int n_tot  = 0;

    // Observed pulses in the last window, and the model's expected pulses.
    int         pk[$];
    logic [3:0] pv[$];
    logic       pw[$];
    int         wrap_n;
    int         ek[$];
    logic [3:0] ev[$];
    logic       ew[$];

    logic [3:0] exp_a;
    logic [3:0] m_a;
    int         m_next;

    always #5 clk = ~clk;

    nibble_sequencer #(
        .DEBOUNCE_CYCLES(DEB),
        .TICK_DIV       (TDIV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw       (sw),
        .btn_load (btn_load),
        .btn_step (btn_step),
        .mode_auto(mode_auto),
        .a        (a),
        .a_valid  (a_valid),
        .wrap     (wrap)
    );

    // Entered at a negedge; buttons in btns rise so that the next posedge is edge k=0.
    task automatic run_window(input logic [1:0] btns, input int hold, input int total);
        pk.delete(); pv.delete(); pw.delete();
        wrap_n   = 0;
        btn_load = btns[0];
        btn_step = btns[1];
        for (int k = 0; k < total; k++) begin
            @(negedge clk);
            if (a_valid === 1'b1) begin
                pk.push_back(k);
                pv.push_back(a);
                pw.push_back(wrap);
            end
            if (wrap === 1'b1) wrap_n++;
            if (k == hold - 1) begin
                btn_load = 1'b0;
                btn_step = 1'b0;
            end
        end
    endtask

    // Auto-mode model: increments every TDIV edges, a load restarts the period.
    task automatic auto_model(input int total, input int load_k, input logic [3:0] load_v);
        ek.delete(); ev.delete(); ew.delete();
        for (int k = 0; k < total; k++) begin
            if (k == load_k) begin
                m_a    = load_v;
                m_next = k + TDIV;
                ek.push_back(k); ev.push_back(m_a); ew.push_back(1'b0);
            end else if (k == m_next) begin
                m_a    = m_a + 4'd1;
                m_next = k + TDIV;
                ek.push_back(k); ev.push_back(m_a); ew.push_back(m_a == 4'd0);
            end
        end
        m_next = m_next - total;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sw        = 4'($urandom);
            btn_load  = 1'($urandom);
            btn_step  = 1'($urandom);
            mode_auto = 1'($urandom);
            @(negedge clk);
            n_tot++;
            if ({a, a_valid, wrap} !== 6'b0) $display("FAIL reset_hold: got a=%0d v=%0b w=%0b expected 0/0/0", a, a_valid, wrap);
            else n_pass++;
        end
        sw = 4'd0; btn_load = 1'b0; btn_step = 1'b0; mode_auto = 1'b0;
        rst_n = 1'b1;
        run_window(2'b00, 0, 10);
        n_tot++;
        if (pk.size() != 0 || a !== 4'd0) $display("FAIL reset_release: got pulses=%0d a=%0d expected 0/0", pk.size(), a);
        else n_pass++;
        exp_a = 4'd0;
    endtask

    task automatic test_load;
        sw = 4'b1010;
        run_window(2'b01, 40, 70);
        n_tot++;
        if (pk.size() != 1) $display("FAIL load_count: got %0d pulses expected 1", pk.size());
        else n_pass++;
        if (pk.size() == 1) begin
            n_tot++;
            if (pk[0] != LAT || pv[0] !== 4'd10) $display("FAIL load_value: got edge %0d a=%0d expected edge %0d a=10", pk[0], pv[0], LAT);
            else n_pass++;
        end
        n_tot++;
        if (wrap_n != 0) $display("FAIL load_wrap: got %0d wrap pulses expected 0", wrap_n);
        else n_pass++;
        exp_a = 4'd10;
    endtask

    task automatic test_step_wrap;
        sw = 4'd14;
        run_window(2'b01, 25, 50);
        exp_a = 4'd14;
        n_tot++;
        if (a !== exp_a) $display("FAIL step_preload: got a=%0d expected %0d", a, exp_a);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            run_window(2'b10, 30, 55);
            exp_a = exp_a + 4'd1;
            n_tot++;
            if (pk.size() != 1 || pk[0] != LAT || pv[0] !== exp_a)
                $display("FAIL step_%0d: got %0d pulses a=%0d expected 1 pulse at edge %0d a=%0d", i, pk.size(), a, LAT, exp_a);
            else n_pass++;
            n_tot++;
            if (wrap_n != ((exp_a == 4'd0) ? 1 : 0)) $display("FAIL step_wrap_%0d: got %0d wrap pulses expected %0d", i, wrap_n, (exp_a == 4'd0) ? 1 : 0);
            else n_pass++;
        end
    endtask

    task automatic test_glitch;
        run_window(2'b10, 10, 40);
        n_tot++;
        if (pk.size() != 0 || a !== exp_a) $display("FAIL glitch: got %0d pulses a=%0d expected 0 pulses a=%0d", pk.size(), a, exp_a);
        else n_pass++;
    endtask

    task automatic test_priority;
        sw = 4'd5;
        run_window(2'b11, 30, 55);
        exp_a = 4'd5;
        n_tot++;
        if (pk.size() != 1 || pk[0] != LAT || pv[0] !== exp_a)
            $display("FAIL priority: got %0d pulses a=%0d expected 1 pulse at edge %0d a=5", pk.size(), a, LAT);
        else n_pass++;
    endtask

    task automatic test_random_manual;
        int   op, hold, exp_n, exp_w;
        for (int i = 0; i < 8; i++) begin
            op    = int'($urandom_range(0, 2));
            exp_w = 0;
            if (op == 2) begin
                hold  = int'($urandom_range(1, DEB - 2));
                exp_n = 0;
                run_window(2'b10, hold, hold + 25);
            end else begin
                hold  = int'($urandom_range(DEB + 2, 40));
                exp_n = 1;
                if (op == 0) begin
                    sw    = 4'($urandom);
                    exp_a = sw;
                    run_window(2'b01, hold, hold + 25);
                end else begin
                    exp_w = (exp_a == 4'hF) ? 1 : 0;
                    exp_a = exp_a + 4'd1;
                    run_window(2'b10, hold, hold + 25);
                end
            end
            n_tot++;
            if (pk.size() != exp_n || a !== exp_a || wrap_n != exp_w)
                $display("FAIL rand_%0d_op%0d: got pulses=%0d a=%0d wraps=%0d expected %0d/%0d/%0d", i, op, pk.size(), a, wrap_n, exp_n, exp_a, exp_w);
            else n_pass++;
            if (exp_n == 1 && pk.size() == 1) begin
                n_tot++;
                if (pk[0] != LAT) $display("FAIL rand_%0d_latency: got edge %0d expected %0d", i, pk[0], LAT);
                else n_pass++;
            end
        end
    endtask

    task automatic test_auto;
        logic [1:0] btns;
        int         hold, total, load_k;
        sw = 4'd13;
        run_window(2'b01, 25, 50);
        m_a = 4'd13;
        n_tot++;
        if (a !== 4'd13) $display("FAIL auto_preload: got a=%0d expected 13", a);
        else n_pass++;
        mode_auto = 1'b1;
        m_next    = 6;  // two sync edges, then TDIV after entering AUTO
        for (int s = 0; s < 3; s++) begin
            case (s)
                0:       begin btns = 2'b00; hold = 0;  total = 20; load_k = -1; end
                1:       begin btns = 2'b01; hold = 30; total = 40; load_k = LAT; sw = 4'd3; end
                default: begin btns = 2'b10; hold = 30; total = 50; load_k = -1; end
            endcase
            auto_model(total, load_k, sw);
            run_window(btns, hold, total);
            n_tot++;
            if (pk.size() != ek.size()) $display("FAIL auto_%0d_count: got %0d pulses expected %0d", s, pk.size(), ek.size());
            else n_pass++;
            for (int j = 0; j < pk.size() && j < ek.size(); j++) begin
                n_tot++;
                if (pk[j] != ek[j] || pv[j] !== ev[j] || pw[j] !== ew[j])
                    $display("FAIL auto_%0d_pulse%0d: got edge %0d a=%0d w=%0b expected edge %0d a=%0d w=%0b",
                             s, j, pk[j], pv[j], pw[j], ek[j], ev[j], ew[j]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid_auto;
        sw = 4'd6;
        auto_model(25, LAT, sw);
        run_window(2'b01, 25, 25);
        n_tot++;
        if (a !== 4'd7) $display("FAIL mid_auto_pre: got a=%0d expected 7", a);
        else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        n_tot++;
        if ({a, a_valid, wrap} !== 6'b0) $display("FAIL mid_auto_async: got a=%0d v=%0b w=%0b expected 0/0/0", a, a_valid, wrap);
        else n_pass++;
        mode_auto = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_window(2'b00, 0, 25);
        n_tot++;
        if (pk.size() != 0 || a !== 4'd0) $display("FAIL mid_auto_release: got pulses=%0d a=%0d expected 0/0", pk.size(), a);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_load();
        test_step_wrap();
        test_glitch();
        test_priority();
        test_random_manual();
        test_auto();
        test_reset_mid_auto();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
